hawk_req_router: RTL and testbench
==================================

Name: hawk_req_router

Overview:
One-to-many request router, the opposite direction of the round-robin arbiter.
- A single upstream requester uses the hold-valid-until-done protocol.
- The router decodes a destination index from a field of the request, then forwards the request to exactly one of N servers.
- It returns that server's response upstream, with a done pulse.
- It adds decode-error and timeout handling so a bad index or a hung server cannot deadlock the requester.

Parameters:
Breq, 16, request word width.
Brsp, 16, response word width.
output_cnt, 3, number of downstream servers (>=2).
SEL_LSB, 14, LSB of the destination-index field in the request. Field width SELW = $clog2(output_cnt). SEL_LSB+SELW <= Breq.
TIMEOUT_CYC, 8, maximum cycles to wait for a server done. 0 disables the timeout.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, asynchronous, active-high.
in_req  in  Breq  upstream request word.
in_valid  in  1  upstream request valid, held until in_done.
in_rsp  out  Brsp  upstream response, meaningful only while in_done=1.
in_done  out  1  one-cycle completion pulse to upstream.
out_req  out  [output_cnt][Breq]  per-server request word.
out_valid  out  [output_cnt]  per-server request valid, held until that server's done.
out_rsp  in  [output_cnt][Brsp]  per-server response, sampled when the matching out_done=1.
out_done  in  [output_cnt]  per-server one-cycle completion.
cur_sel  out  $clog2(output_cnt)  index of the server currently or last targeted.
err_decode  out  1  sticky flag: an out-of-range index was seen.
err_timeout  out  1  sticky flag: a timeout occurred.
err_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (async, rst_i=1):
  - State goes to IDLE.
  - Every output is 0: out_valid, out_req (all lanes), in_done, in_rsp, cur_sel, err_decode, err_timeout.
  - The internal request latch, response latch and timeout counter are cleared.
  - Reset asserted mid-transaction drops out_valid immediately and gives no in_done. A late out_done after reset is ignored.
- Request-path outputs are all registered.
- State machine: IDLE, ISSUE, RESP, ERR.
- IDLE:
  - in_done=0, all out_valid=0.
  - If in_valid=1, latch in_req and compute sel = in_req[SEL_LSB +: SELW].
  - If sel < output_cnt: cur_sel<=sel, go to ISSUE.
  - Otherwise: set err_decode, go to ERR.
- ISSUE:
  - out_valid[cur_sel]=1 and out_req[cur_sel]=latched request. All other lanes have valid=0 and req=0.
  - The timeout counter increments each cycle in ISSUE.
  - If out_done[cur_sel]=1: latch out_rsp[cur_sel], go to RESP. out_valid drops the next cycle.
  - Else if TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1: set err_timeout, drop out_valid, go to ERR.
  - If done and timeout occur in the same cycle, done wins.
  - out_done on any lane other than cur_sel is ignored in every state, and so is out_done on any lane outside ISSUE.
- RESP: in_done=1 for exactly one cycle, in_rsp=latched response, then go to IDLE.
- ERR: in_done=1 for exactly one cycle, in_rsp={Brsp{1'b1}}, then go to IDLE.
- in_rsp returns to 0 whenever in_done=0.
- Latency:
  - in_valid rises in cycle 0 (IDLE): out_valid[sel] is high from cycle 1.
  - out_done in cycle k: in_done in cycle k+1.
  - Decode error: in_done in cycle 1.
  - Minimum turnaround is 3 cycles per request.
- Back-to-back: in_valid still high in IDLE (cycle after in_done) is treated as a new request. There is no dead cycle beyond IDLE.
- in_req and in_valid changing while in ISSUE are ignored, because the request is latched.
- Timeout counter: clears on entry to ISSUE. Width is $clog2(TIMEOUT_CYC+1), min 1. It saturates and never wraps.
- Sticky flags: err_clr=1 clears them next cycle. If a set and err_clr occur in the same cycle, the set wins.
- cur_sel holds its value outside ISSUE.

Test Plan:
1. Basic route: output_cnt=3, in_req=16'h4ABC (sel=1), in_valid=1 at cycle 0 -> out_valid=3'b010 from cycle 1, out_req[1]=16'h4ABC. out_done[1]=1 with out_rsp[1]=16'h1234 at cycle 4 -> in_done=1, in_rsp=16'h1234 at cycle 5 only. out_valid=0 from cycle 5.
2. Decode error: in_req=16'hC000 (sel=3) -> no out_valid ever, in_done=1 with in_rsp=16'hFFFF at cycle 1, err_decode=1 sticky. err_clr pulse -> err_decode=0 next cycle.
3. Timeout: TIMEOUT_CYC=8, sel=2, server never responds -> out_valid[2] high for exactly 8 cycles (1..8), in_done with 16'hFFFF at cycle 9, err_timeout=1. A late out_done[2] at cycle 12 produces no in_done.
4. Done/timeout tie: out_done[2] asserted in the 8th ISSUE cycle -> RESP path, in_rsp=out_rsp[2], err_timeout stays 0.
5. Stray done plus back-to-back:
   - While targeting sel=0, pulse out_done[1] -> ignored, out_valid[0] stays 1.
   - Then complete sel=0, with in_valid held high and in_req changed to sel=2 -> in_done, then one IDLE cycle, then out_valid[2].
6. Async reset mid-ISSUE: assert rst_i in cycle 3 of a sel=1 request -> all outputs 0 immediately, no in_done. After release, a fresh request routes normally.

Source files
------------

// File: rtl/hawk_req_router.sv
`default_nettype none
// ============================================================================
// Module      : hawk_req_router
// Description : One-to-many request router. Decodes a destination index from
//               the upstream request, forwards it to exactly one server, and
//               returns that server's response upstream with a done pulse.
//               Out-of-range indices and hung servers complete upstream with
//               an all-ones error response and set sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module hawk_req_router #(
  parameter int unsigned Breq        = 16,
  parameter int unsigned Brsp        = 16,
  parameter int unsigned output_cnt  = 3,
  parameter int unsigned SEL_LSB     = 14,
  parameter int unsigned TIMEOUT_CYC = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [Breq-1:0]                     in_req,
  input  logic                                in_valid,
  output logic [Brsp-1:0]                     in_rsp,
  output logic                                in_done,
  output logic [output_cnt-1:0][Breq-1:0]     out_req,
  output logic [output_cnt-1:0]               out_valid,
  input  logic [output_cnt-1:0][Brsp-1:0]     out_rsp,
  input  logic [output_cnt-1:0]               out_done,
  output logic [$clog2(output_cnt)-1:0]       cur_sel,
  output logic                                err_decode,
  output logic                                err_timeout,
  input  logic                                err_clr
);

  localparam int unsigned c_SELW = $clog2(output_cnt);
  localparam int unsigned c_CNTW = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNTW-1:0] c_CNT_MAX  = {c_CNTW{1'b1}};
  localparam logic [c_CNTW-1:0] c_CNT_LAST = c_CNTW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t                          r_state;
  logic [c_SELW-1:0]               r_sel;
  logic [c_CNTW-1:0]               r_cnt;
  logic [Brsp-1:0]                 r_rsp;
  logic                            r_done;
  logic [output_cnt-1:0]           r_out_valid;
  logic [output_cnt-1:0][Breq-1:0] r_out_req;
  logic                            r_err_decode;
  logic                            r_err_timeout;

  logic [c_SELW-1:0]               w_sel;
  logic                            w_sel_ok;
  logic [output_cnt-1:0]           w_new_valid;
  logic [output_cnt-1:0][Breq-1:0] w_new_req;
  logic                            w_tgt_done;
  logic [Brsp-1:0]                 w_tgt_rsp;
  logic                            w_timeout;
  logic                            w_set_decode;
  logic                            w_set_timeout;

  // Destination index taken straight from the incoming word; only used in IDLE.
  assign w_sel    = in_req[SEL_LSB +: c_SELW];
  assign w_sel_ok = (32'(w_sel) < output_cnt);

  // Timeout fires on the last allowed ISSUE cycle; disabled when TIMEOUT_CYC is 0.
  assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == c_CNT_LAST);

  assign w_set_decode  = (r_state == S_IDLE) && in_valid && !w_sel_ok;
  assign w_set_timeout = (r_state == S_ISSUE) && !w_tgt_done && w_timeout;

  // Lane steering for a new request and selection of the targeted server's done/response.
  always_comb begin
    w_new_valid = '0;
    w_new_req   = '0;
    w_tgt_done  = 1'b0;
    w_tgt_rsp   = '0;
    for (int i = 0; i < int'(output_cnt); i++) begin
      if (w_sel == c_SELW'(i)) begin
        w_new_valid[i] = 1'b1;
        w_new_req[i]   = in_req;
      end
      if (r_sel == c_SELW'(i)) begin
        w_tgt_done = out_done[i];
        w_tgt_rsp  = out_rsp[i];
      end
    end
  end

  // Main routing state machine; all request-path outputs are registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_rsp       <= '0;
      r_done      <= 1'b0;
      r_out_valid <= '0;
      r_out_req   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done      <= 1'b0;
          r_rsp       <= '0;
          r_out_valid <= '0;
          r_out_req   <= '0;
          if (in_valid) begin
            if (w_sel_ok) begin
              // The registered lane request doubles as the request latch.
              r_sel       <= w_sel;
              r_cnt       <= '0;
              r_out_valid <= w_new_valid;
              r_out_req   <= w_new_req;
              r_state     <= S_ISSUE;
            end else begin
              r_done  <= 1'b1;
              r_rsp   <= {Brsp{1'b1}};
              r_state <= S_ERR;
            end
          end
        end

        S_ISSUE: begin
          if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
          // A server done beats a simultaneous timeout.
          if (w_tgt_done) begin
            r_rsp       <= w_tgt_rsp;
            r_done      <= 1'b1;
            r_out_valid <= '0;
            r_out_req   <= '0;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_rsp       <= {Brsp{1'b1}};
            r_done      <= 1'b1;
            r_out_valid <= '0;
            r_out_req   <= '0;
            r_state     <= S_ERR;
          end
        end

        S_RESP, S_ERR: begin
          r_done  <= 1'b0;
          r_rsp   <= '0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done      <= 1'b0;
          r_rsp       <= '0;
          r_out_valid <= '0;
          r_out_req   <= '0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags: a new error event takes priority over a clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_decode  <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_set_decode) begin
        r_err_decode <= 1'b1;
      end else if (err_clr) begin
        r_err_decode <= 1'b0;
      end
      if (w_set_timeout) begin
        r_err_timeout <= 1'b1;
      end else if (err_clr) begin
        r_err_timeout <= 1'b0;
      end
    end
  end

  assign in_rsp      = r_rsp;
  assign in_done     = r_done;
  assign out_valid   = r_out_valid;
  assign out_req     = r_out_req;
  assign cur_sel     = r_sel;
  assign err_decode  = r_err_decode;
  assign err_timeout = r_err_timeout;

  a_valid_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(out_valid));
  a_done_pulse:   assert property (@(posedge clk_i) disable iff (rst_i) in_done |=> !in_done);

endmodule
`default_nettype wire

// File: tb/tb_hawk_req_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_hawk_req_router
// Description : Self-checking bench for hawk_req_router (3 servers, 8-cycle
//               timeout). Table-driven transactions plus hand sequences for
//               stray/late dones, back-to-back requests and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hawk_req_router;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [15:0]           in_req;
  logic                  in_valid;
  logic [15:0]           in_rsp;
  logic                  in_done;
  logic [2:0][15:0]      out_req;
  logic [2:0]            out_valid;
  logic [2:0][15:0]      out_rsp;
  logic [2:0]            out_done;
  logic [1:0]            cur_sel;
  logic                  err_decode;
  logic                  err_timeout;
  logic                  err_clr;

  int n_cmp  = 0;
  int n_fail = 0;
  int model_sel = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] req;
    logic [2:0]  exp_valid;
    int          lane;
    int          resp_cyc;   // ISSUE cycle in which the server answers, 0 = never
    logic [15:0] rsp;
    logic [15:0] exp_rsp;
    int          exp_done;   // cycle of in_done, counted from in_valid rising in cycle 0
    bit          exp_dec;
    bit          exp_to;
  } vec_t;

  vec_t vecs[7];

  hawk_req_router #(
    .Breq(16), .Brsp(16), .output_cnt(3), .SEL_LSB(14), .TIMEOUT_CYC(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_req(in_req), .in_valid(in_valid), .in_rsp(in_rsp), .in_done(in_done),
    .out_req(out_req), .out_valid(out_valid), .out_rsp(out_rsp), .out_done(out_done),
    .cur_sel(cur_sel), .err_decode(err_decode), .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: every completion must match the oldest expected response.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (in_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: in_done=1 in_rsp=%0h, required no completion", in_rsp);
        end else begin
          check("in_rsp", 64'(in_rsp), 64'(exp_q.pop_front()));
        end
      end else begin
        check("in_rsp_idle", 64'(in_rsp), 64'd0);
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    logic [2:0][15:0] er;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3; i++) er[i] = v.exp_valid[i] ? v.req : 16'h0;
    in_req   = v.req;
    in_valid = 1'b1;
    exp_q.push_back(v.exp_rsp);
    if (!v.exp_dec) model_sel = v.lane;
    for (int c = 1; c <= 16 && !got; c++) begin
      tick();
      out_done = '0;
      if (in_done) begin
        got = 1'b1;
        check({tag, " done_cycle"}, 64'(c), 64'(v.exp_done));
        check({tag, " valid_after_done"}, 64'(out_valid), 64'd0);
        check({tag, " err_decode"}, 64'(err_decode), 64'(v.exp_dec));
        check({tag, " err_timeout"}, 64'(err_timeout), 64'(v.exp_to));
        check({tag, " cur_sel"}, 64'(cur_sel), 64'(model_sel));
        in_valid = 1'b0;
      end else begin
        check({tag, " out_valid"}, 64'(out_valid), 64'(v.exp_valid));
        check({tag, " out_req"}, 64'(out_req), 64'(er));
        if (c == v.resp_cyc) begin
          out_done[v.lane] = 1'b1;
          out_rsp[v.lane]  = v.rsp;
        end
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s no_done: in_done never asserted within 16 cycles, required cycle %0d", tag, v.exp_done);
      in_valid = 1'b0;
      out_done = '0;
    end
    tick();
    check({tag, " done_pulse_end"}, 64'(in_done), 64'd0);
    check({tag, " err_decode_sticky"}, 64'(err_decode), 64'(v.exp_dec));
    check({tag, " err_timeout_sticky"}, 64'(err_timeout), 64'(v.exp_to));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check({tag, " err_decode_clr"}, 64'(err_decode), 64'd0);
    check({tag, " err_timeout_clr"}, 64'(err_timeout), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    //           req       valid  lane resp rsp       exp_rsp   done dec to
    vecs[0] = '{16'h4ABC, 3'b010, 1,   4,   16'h1234, 16'h1234, 5,   1'b0, 1'b0};
    vecs[1] = '{16'hC000, 3'b000, 0,   0,   16'h0000, 16'hFFFF, 1,   1'b1, 1'b0};
    vecs[2] = '{16'h8055, 3'b100, 2,   0,   16'h0000, 16'hFFFF, 9,   1'b0, 1'b1};
    vecs[3] = '{16'h8077, 3'b100, 2,   8,   16'hBEEF, 16'hBEEF, 9,   1'b0, 1'b0};
    vecs[4] = '{16'h0123, 3'b001, 0,   1,   16'h5A5A, 16'h5A5A, 2,   1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 3'b010, 1,   2,   16'hA001, 16'hA001, 3,   1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 3'b000, 0,   0,   16'h0000, 16'hFFFF, 1,   1'b1, 1'b0};

    rst_i    = 1'b1;
    in_req   = '0;
    in_valid = 1'b0;
    out_rsp  = '0;
    out_done = '0;
    err_clr  = 1'b0;
    tick();
    tick();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_req", 64'(out_req), 64'd0);
    check("reset in_done", 64'(in_done), 64'd0);
    check("reset in_rsp", 64'(in_rsp), 64'd0);
    check("reset cur_sel", 64'(cur_sel), 64'd0);
    check("reset err_decode", 64'(err_decode), 64'd0);
    check("reset err_timeout", 64'(err_timeout), 64'd0);
    rst_i = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // Timeout followed by a late server done that must be ignored.
    begin
      int done_c;
      done_c = 0;
      in_req   = 16'h8000;
      in_valid = 1'b1;
      exp_q.push_back(16'hFFFF);
      for (int c = 1; c <= 12; c++) begin
        tick();
        out_done = '0;
        if (in_done) begin
          done_c   = c;
          in_valid = 1'b0;
        end
        if (c == 12) begin
          out_done[2] = 1'b1;
          out_rsp[2]  = 16'h1111;
        end
      end
      check("late done_cycle", 64'(done_c), 64'd9);
      for (int c = 0; c < 3; c++) begin
        tick();
        out_done = '0;
        check("late no_done", 64'(in_done), 64'd0);
        check("late no_valid", 64'(out_valid), 64'd0);
      end
      check("late err_timeout", 64'(err_timeout), 64'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      model_sel = 2;
    end

    // Stray done on a non-target lane, ignored request change, back-to-back.
    in_req   = 16'h0001;
    in_valid = 1'b1;
    exp_q.push_back(16'h0A0A);
    tick();
    check("b2b c1 out_valid", 64'(out_valid), 64'b001);
    check("b2b c1 cur_sel", 64'(cur_sel), 64'd0);
    tick();
    out_done[1] = 1'b1;
    out_rsp[1]  = 16'hDEAD;
    in_req      = 16'h8002;
    tick();
    out_done = '0;
    check("b2b stray out_valid", 64'(out_valid), 64'b001);
    check("b2b stray in_done", 64'(in_done), 64'd0);
    check("b2b latched out_req0", 64'(out_req[0]), 64'h0001);
    out_done[0] = 1'b1;
    out_rsp[0]  = 16'h0A0A;
    exp_q.push_back(16'hC0DE);
    tick();
    out_done = '0;
    check("b2b first in_done", 64'(in_done), 64'd1);
    check("b2b first valid_drop", 64'(out_valid), 64'd0);
    tick();
    check("b2b idle in_done", 64'(in_done), 64'd0);
    check("b2b idle out_valid", 64'(out_valid), 64'd0);
    tick();
    check("b2b second out_valid", 64'(out_valid), 64'b100);
    check("b2b second out_req2", 64'(out_req[2]), 64'h8002);
    check("b2b second cur_sel", 64'(cur_sel), 64'd2);
    out_done[2] = 1'b1;
    out_rsp[2]  = 16'hC0DE;
    tick();
    out_done = '0;
    check("b2b second in_done", 64'(in_done), 64'd1);
    in_valid = 1'b0;
    tick();
    check("b2b end in_done", 64'(in_done), 64'd0);

    // Async reset in the middle of an ISSUE phase.
    in_req   = 16'h4000;
    in_valid = 1'b1;
    tick();
    tick();
    check("rst pre out_valid", 64'(out_valid), 64'b010);
    tick();
    rst_i    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst async out_valid", 64'(out_valid), 64'd0);
    check("rst async out_req", 64'(out_req), 64'd0);
    check("rst async cur_sel", 64'(cur_sel), 64'd0);
    check("rst async in_done", 64'(in_done), 64'd0);
    tick();
    tick();
    rst_i = 1'b0;
    model_sel = 0;
    out_done[1] = 1'b1;
    out_rsp[1]  = 16'h2222;
    tick();
    out_done = '0;
    check("rst late in_done", 64'(in_done), 64'd0);
    tick();
    check("rst late in_done2", 64'(in_done), 64'd0);
    begin
      vec_t fresh;
      fresh = '{16'h4321, 3'b010, 1, 3, 16'h7777, 16'h7777, 4, 1'b0, 1'b0};
      run_vec(fresh, "post_rst");
    end

    check("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
